// File: rtl/sprite_pkg.sv
// Shared descriptor type and the power-on sprite table contents.
package sprite_pkg;

  localparam int unsigned SPR_ADDR_W   = 25;
  localparam int unsigned SPR_DIM_W    = 10;
  localparam int unsigned NUM_DEFAULTS = 14;

  typedef struct packed {
    logic                  valid;
    logic [SPR_ADDR_W-1:0] base;
    logic [SPR_DIM_W-1:0]  width;
    logic [SPR_DIM_W-1:0]  height;
  } sprite_desc_t;

  // Two 64x48 player frames, an unused slot, then eleven 32x32 enemy frames packed after them.
  localparam sprite_desc_t SPRITE_DEFAULTS [NUM_DEFAULTS] = '{
    '{1'b1, 25'd307200, 10'd64, 10'd48},
    '{1'b1, 25'd310272, 10'd64, 10'd48},
    '{1'b0, 25'd0,      10'd0,  10'd0 },
    '{1'b1, 25'd313344, 10'd32, 10'd32},
    '{1'b1, 25'd314368, 10'd32, 10'd32},
    '{1'b1, 25'd315392, 10'd32, 10'd32},
    '{1'b1, 25'd316416, 10'd32, 10'd32},
    '{1'b1, 25'd317440, 10'd32, 10'd32},
    '{1'b1, 25'd318464, 10'd32, 10'd32},
    '{1'b1, 25'd319488, 10'd32, 10'd32},
    '{1'b1, 25'd320512, 10'd32, 10'd32},
    '{1'b1, 25'd321536, 10'd32, 10'd32},
    '{1'b1, 25'd322560, 10'd32, 10'd32},
    '{1'b1, 25'd323584, 10'd32, 10'd32}
  };

  function automatic sprite_desc_t default_desc(int unsigned idx);
    if (idx < NUM_DEFAULTS) return SPRITE_DEFAULTS[idx[3:0]];
    return '0;
  endfunction

endpackage

// File: rtl/sprite_desc_ram.sv
// Sprite descriptor register file: one write port, one combinational read port,
// reset loads the package defaults.
module sprite_desc_ram
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 16,
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned DIM_W       = 10,
  parameter int unsigned ID_W        = $clog2(NUM_SPRITES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ID_W-1:0]   wr_id,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [DIM_W-1:0]  wr_width,
  input  logic [DIM_W-1:0]  wr_height,
  input  logic              wr_inval,
  input  logic [ID_W-1:0]   rd_id,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_base,
  output logic [DIM_W-1:0]  rd_width,
  output logic [DIM_W-1:0]  rd_height
);

  logic              valid_q  [NUM_SPRITES];
  logic [ADDR_W-1:0] base_q   [NUM_SPRITES];
  logic [DIM_W-1:0]  width_q  [NUM_SPRITES];
  logic [DIM_W-1:0]  height_q [NUM_SPRITES];

  sprite_desc_t rst_tbl [NUM_SPRITES];

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : gen_rst_tbl
    assign rst_tbl[g] = default_desc(g);
  end

  logic wr_id_ok;
  logic rd_id_ok;
  assign wr_id_ok = 32'(wr_id) < NUM_SPRITES;
  assign rd_id_ok = 32'(rd_id) < NUM_SPRITES;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        valid_q[i]  <= rst_tbl[i].valid;
        base_q[i]   <= ADDR_W'(rst_tbl[i].base);
        width_q[i]  <= DIM_W'(rst_tbl[i].width);
        height_q[i] <= DIM_W'(rst_tbl[i].height);
      end
    end else if (wr_en && wr_id_ok) begin
      if (wr_inval) begin
        valid_q[wr_id] <= 1'b0;
      end else begin
        valid_q[wr_id]  <= 1'b1;
        base_q[wr_id]   <= wr_base;
        width_q[wr_id]  <= wr_width;
        height_q[wr_id] <= wr_height;
      end
    end
  end

  // Out-of-range ids read back as an invalid, all-zero entry.
  always_comb begin
    rd_valid  = 1'b0;
    rd_base   = '0;
    rd_width  = '0;
    rd_height = '0;
    if (rd_id_ok) begin
      rd_valid  = valid_q[rd_id];
      rd_base   = base_q[rd_id];
      rd_width  = width_q[rd_id];
      rd_height = height_q[rd_id];
    end
  end

endmodule

// File: rtl/sprite_addr_gen.sv
// Sprite pixel-address generator: descriptor lookup in S1, y*width+x+base and bounds
// check in S2, valid/ready on both sides.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 16,
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned DIM_W       = 10,
  parameter int unsigned ID_W        = $clog2(NUM_SPRITES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ID_W-1:0]   wr_id,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [DIM_W-1:0]  wr_width,
  input  logic [DIM_W-1:0]  wr_height,
  input  logic              wr_inval,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ID_W-1:0]   in_id,
  input  logic [DIM_W-1:0]  in_x,
  input  logic [DIM_W-1:0]  in_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_hit,
  output logic [DIM_W-1:0]  out_width,
  output logic [DIM_W-1:0]  out_height
);

  logic              rd_valid;
  logic [ADDR_W-1:0] rd_base;
  logic [DIM_W-1:0]  rd_width;
  logic [DIM_W-1:0]  rd_height;

  sprite_desc_ram #(
    .NUM_SPRITES(NUM_SPRITES),
    .ADDR_W     (ADDR_W),
    .DIM_W      (DIM_W),
    .ID_W       (ID_W)
  ) u_desc_ram (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_id    (wr_id),
    .wr_base  (wr_base),
    .wr_width (wr_width),
    .wr_height(wr_height),
    .wr_inval (wr_inval),
    .rd_id    (in_id),
    .rd_valid (rd_valid),
    .rd_base  (rd_base),
    .rd_width (rd_width),
    .rd_height(rd_height)
  );

  logic              s1_valid;
  logic              s1_ent_valid;
  logic [ADDR_W-1:0] s1_base;
  logic [DIM_W-1:0]  s1_width;
  logic [DIM_W-1:0]  s1_height;
  logic [DIM_W-1:0]  s1_x;
  logic [DIM_W-1:0]  s1_y;

  logic                 s2_advance;
  logic [2*DIM_W-1:0]   prod;
  logic [ADDR_W-1:0]    sum;
  logic                 hit;

  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;

  always_comb begin
    prod = (2*DIM_W)'(s1_y) * (2*DIM_W)'(s1_width);
    sum  = s1_base + ADDR_W'(prod) + ADDR_W'(s1_x);
    hit  = s1_ent_valid && (s1_x < s1_width) && (s1_y < s1_height);
  end

  // S1: the table is sampled as the request enters, so a same-cycle write is not seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_ent_valid <= 1'b0;
      s1_base      <= '0;
      s1_width     <= '0;
      s1_height    <= '0;
      s1_x         <= '0;
      s1_y         <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_ent_valid <= rd_valid;
        s1_base      <= rd_base;
        s1_width     <= rd_width;
        s1_height    <= rd_height;
        s1_x         <= in_x;
        s1_y         <= in_y;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_hit    <= 1'b0;
      out_width  <= '0;
      out_height <= '0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_addr   <= hit ? sum : '0;
        out_hit    <= hit;
        out_width  <= s1_ent_valid ? s1_width : '0;
        out_height <= s1_ent_valid ? s1_height : '0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Directed and randomized bench for sprite_addr_gen with a table-level reference model.
module tb_sprite_addr_gen;

  localparam int unsigned NUM_SPRITES = 16;
  localparam int unsigned ADDR_W      = 25;
  localparam int unsigned DIM_W       = 10;
  localparam int unsigned ID_W        = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ID_W-1:0]   wr_id;
  logic [ADDR_W-1:0] wr_base;
  logic [DIM_W-1:0]  wr_width;
  logic [DIM_W-1:0]  wr_height;
  logic              wr_inval;
  logic              in_valid;
  logic              in_ready;
  logic [ID_W-1:0]   in_id;
  logic [DIM_W-1:0]  in_x;
  logic [DIM_W-1:0]  in_y;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic              out_hit;
  logic [DIM_W-1:0]  out_width;
  logic [DIM_W-1:0]  out_height;

  sprite_addr_gen #(
    .NUM_SPRITES(NUM_SPRITES),
    .ADDR_W     (ADDR_W),
    .DIM_W      (DIM_W),
    .ID_W       (ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_id     (wr_id),
    .wr_base   (wr_base),
    .wr_width  (wr_width),
    .wr_height (wr_height),
    .wr_inval  (wr_inval),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_id     (in_id),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_hit   (out_hit),
    .out_width (out_width),
    .out_height(out_height)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    bit          hit;
    int unsigned w;
    int unsigned h;
  } exp_t;

  bit          m_valid [NUM_SPRITES];
  int unsigned m_base  [NUM_SPRITES];
  int unsigned m_w     [NUM_SPRITES];
  int unsigned m_h     [NUM_SPRITES];
  exp_t        q [$];

  int  tests = 0;
  int  fails = 0;
  int  recv  = 0;
  bit  last_rdy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Players at 307200 (64x48 each), slot 2 empty, enemies 32x32 packed from 313344.
  task automatic init_model();
    for (int i = 0; i < int'(NUM_SPRITES); i++) begin
      m_valid[i] = 0; m_base[i] = 0; m_w[i] = 0; m_h[i] = 0;
      if (i < 2) begin
        m_valid[i] = 1; m_base[i] = 307200 + i * 64 * 48; m_w[i] = 64; m_h[i] = 48;
      end else if (i >= 3 && i <= 13) begin
        m_valid[i] = 1; m_base[i] = 313344 + (i - 3) * 32 * 32; m_w[i] = 32; m_h[i] = 32;
      end
    end
  endtask

  function automatic exp_t predict(int unsigned id, int unsigned x, int unsigned y);
    exp_t e;
    e.addr = 0; e.hit = 0; e.w = 0; e.h = 0;
    if (id < NUM_SPRITES && m_valid[id]) begin
      e.w = m_w[id];
      e.h = m_h[id];
      if (x < e.w && y < e.h) begin
        e.hit  = 1;
        e.addr = (m_base[id] + y * e.w + x) % (1 << ADDR_W);
      end
    end
    return e;
  endfunction

  // Called just after a falling edge with inputs driven; scores the coming rising edge.
  task automatic cycle(output bit acc);
    exp_t e;
    #4;
    last_rdy = in_ready;
    acc = in_valid && in_ready && !rst;
    if (out_valid && out_ready && !rst) begin
      recv++;
      if (q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check("res_addr", 64'(out_addr), 64'(e.addr));
        check("res_hit", 64'(out_hit), 64'(e.hit));
        check("res_width", 64'(out_width), 64'(e.w));
        check("res_height", 64'(out_height), 64'(e.h));
      end
    end
    if (acc) q.push_back(predict(in_id, in_x, in_y));
    if (wr_en && !rst && int'(wr_id) < int'(NUM_SPRITES)) begin
      if (wr_inval) m_valid[wr_id] = 0;
      else begin
        m_valid[wr_id] = 1; m_base[wr_id] = wr_base; m_w[wr_id] = wr_width;
        m_h[wr_id] = wr_height;
      end
    end
    @(negedge clk);
  endtask

  task automatic req(input int unsigned id, input int unsigned x, input int unsigned y);
    in_valid = 1'b1;
    in_id    = ID_W'(id);
    in_x     = DIM_W'(x);
    in_y     = DIM_W'(y);
  endtask

  task automatic wr(input int unsigned id, input int unsigned base, input int unsigned w,
                    input int unsigned h, input bit inval);
    wr_en     = 1'b1;
    wr_id     = ID_W'(id);
    wr_base   = ADDR_W'(base);
    wr_width  = DIM_W'(w);
    wr_height = DIM_W'(h);
    wr_inval  = inval;
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    wr_en     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle(acc);
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    bit acc;
    int sent;
    int recv0;
    bit saw_stall;

    rst = 1'b1;
    wr_en = 1'b0; wr_id = '0; wr_base = '0; wr_width = '0; wr_height = '0; wr_inval = 1'b0;
    in_valid = 1'b0; in_id = '0; in_x = '0; in_y = '0; out_ready = 1'b1;
    init_model();
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    check("rst_out_hit", 64'(out_hit), 64'd0);
    check("rst_out_wh", 64'({out_width, out_height}), 64'd0);
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Basic hit and two-cycle latency
    req(0, 3, 2);
    cycle(acc);
    check("t1_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
    check("t1_lat1", 64'(out_valid), 64'd0);
    cycle(acc);
    check("t1_lat2", 64'(out_valid), 64'd1);
    check("t1_addr_const", 64'(out_addr), 64'd307331);
    cycle(acc);

    // Out-of-bounds and invalid-entry misses
    req(0, 64, 0); cycle(acc);
    req(2, 5, 5);  cycle(acc);
    drain();

    // Runtime write, then invalidate
    in_valid = 1'b0;
    wr(15, 1000, 10, 10, 1'b0); cycle(acc);
    wr_en = 1'b0;
    req(15, 9, 9); cycle(acc);
    in_valid = 1'b0;
    cycle(acc);
    check("t3_addr_const", 64'(out_addr), 64'd1099);
    drain();
    wr(15, 0, 0, 0, 1'b1); cycle(acc);
    wr_en = 1'b0; wr_inval = 1'b0;
    req(15, 9, 9); cycle(acc);
    drain();

    // Same-cycle write and lookup of id1 returns the old entry
    wr(1, 5000, 64, 48, 1'b0);
    req(1, 0, 0); cycle(acc);
    wr_en = 1'b0;
    req(1, 0, 0); cycle(acc);
    in_valid = 1'b0;
    check("t4_old_addr", 64'(out_addr), 64'd310272);
    cycle(acc);
    check("t4_new_addr", 64'(out_addr), 64'd5000);
    drain();

    // Eight back-to-back requests with a three-cycle output stall
    sent = 0; saw_stall = 0; recv0 = recv;
    for (int cyc = 0; cyc < 40 && (sent < 8 || q.size() != 0); cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      if (sent < 8) req((sent == 2) ? 3 : sent, sent, sent + 1);
      else in_valid = 1'b0;
      cycle(acc);
      if (!last_rdy) saw_stall = 1;
      if (acc) sent++;
    end
    check("stall_seen", 64'(saw_stall), 64'd1);
    check("stall_sent", 64'(sent), 64'd8);
    check("stall_recv", 64'(recv - recv0), 64'd8);
    drain();

    // Reset with two requests in flight
    req(3, 1, 1); cycle(acc);
    req(4, 2, 2); cycle(acc);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_out_addr", 64'(out_addr), 64'd0);
    check("t6_out_hit", 64'(out_hit), 64'd0);
    q.delete();
    init_model();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t6_no_stale", 64'(out_valid), 64'd0);
      cycle(acc);
    end
    req(1, 0, 0); cycle(acc);
    in_valid = 1'b0;
    cycle(acc);
    check("t6_default_restored", 64'(out_addr), 64'd310272);
    req(15, 0, 0); cycle(acc);
    drain();

    // Randomized traffic with interleaved writes and backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_id     = ID_W'($urandom % NUM_SPRITES);
      in_x      = DIM_W'($urandom % 40);
      in_y      = DIM_W'($urandom % 40);
      out_ready = ($urandom % 4) != 0;
      wr_en     = ($urandom % 8) == 0;
      wr_id     = ID_W'($urandom % NUM_SPRITES);
      wr_inval  = ($urandom % 4) == 0;
      wr_base   = ADDR_W'($urandom);
      wr_width  = DIM_W'($urandom_range(1, 40));
      wr_height = DIM_W'($urandom_range(1, 40));
      cycle(acc);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
